// File: rtl/cache_arbiter_if.sv
// Shared-memory arbitration bus between the I-cache, D-cache and physical memory.
// "master" is the arbiter's view; "slave" is the caches-plus-memory environment.
interface cache_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and D-cache.
// A grant holds until mem_resp; a waiting requester is handed the port with no idle bubble.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input logic             clk,
  input logic             reset,
  cache_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e state_q, state_d;
  // 0: I-cache held the last grant, 1: D-cache did.
  logic   last_grant_q, last_grant_d;

  logic i_req, d_req;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [LINE_WIDTH-1:0] wdata_sel;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = last_grant_q ? StServeI : StServeD;
        end else if (i_req) begin
          state_d = StServeI;
        end else if (d_req) begin
          state_d = StServeD;
        end
      end
      StServeI: begin
        if (bus.mem_resp) begin
          last_grant_d = 1'b0;
          state_d      = d_req ? StServeD : StIdle;
        end
      end
      StServeD: begin
        if (bus.mem_resp) begin
          last_grant_d = 1'b1;
          state_d      = i_req ? StServeI : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    addr_sel      = '0;
    wdata_sel     = '0;
    unique case (state_q)
      StServeI: begin
        bus.mem_read = bus.i_read;
        addr_sel     = {bus.i_address[ADDR_WIDTH-1:4], 4'b0000};
        bus.i_resp   = bus.mem_resp;
      end
      StServeD: begin
        bus.mem_read  = bus.d_read;
        bus.mem_write = bus.d_write;
        addr_sel      = {bus.d_address[ADDR_WIDTH-1:4], 4'b0000};
        wdata_sel     = bus.d_wdata;
        bus.d_resp    = bus.mem_resp;
      end
      default: ;
    endcase
    bus.mem_address = addr_sel;
    bus.mem_wdata   = wdata_sel;
    // Read data is broadcast; only the resp pulse identifies the owner.
    bus.i_rdata     = bus.mem_rdata;
    bus.d_rdata     = bus.mem_rdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, single transactions, round-robin,
// back-to-back handoff, reset mid-transaction and stray mem_resp in IDLE.
module tb_cache_arbiter;

  localparam logic [127:0] LineA5 = {16{8'hA5}};
  localparam logic [127:0] LineWb = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] Line5a = {16{8'h5A}};

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  cache_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

  cache_arbiter #(
    .ADDR_WIDTH(16),
    .LINE_WIDTH(128)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.d_read && bus.d_write))
        else $error("illegal d_read and d_write together");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_strobes cycle %0d: got %b want 0000", c,
                 {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp});
      end
      n_cmp++;
      if ({bus.mem_address, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_buses cycle %0d: addr %h wdata %h want all 0", c,
                 bus.mem_address, bus.mem_wdata);
      end
    end
  endtask

  task automatic test_i_read();
    bus.i_read    = 1'b1;
    bus.i_address = 16'h1234;
    #1;
    n_cmp++;
    if (bus.mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL i_read_same_cycle: mem_read %b want 0", bus.mem_read);
    end
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address} !== {2'b10, 16'h1230}) begin
      n_fail++;
      $display("FAIL i_read_grant: rd %b wr %b addr %h want 1 0 1230", bus.mem_read,
               bus.mem_write, bus.mem_address);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({bus.mem_read, bus.i_resp, bus.d_resp} !== 3'b100) begin
        n_fail++;
        $display("FAIL i_read_wait %0d: rd/iresp/dresp %b want 100", c,
                 {bus.mem_read, bus.i_resp, bus.d_resp});
      end
    end
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = LineA5;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp, bus.i_rdata} !== {2'b10, LineA5}) begin
      n_fail++;
      $display("FAIL i_read_resp: iresp %b dresp %b rdata %h want 1 0 %h", bus.i_resp,
               bus.d_resp, bus.i_rdata, LineA5);
    end
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    bus.i_read    = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.i_resp, bus.mem_address} !== {2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL i_read_idle: rd %b iresp %b addr %h want 0 0 0000", bus.mem_read,
               bus.i_resp, bus.mem_address);
    end
  endtask

  task automatic test_d_write();
    bus.d_write   = 1'b1;
    bus.d_address = 16'h4008;
    bus.d_wdata   = LineWb;
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address} !== {2'b01, 16'h4000}) begin
      n_fail++;
      $display("FAIL d_write_grant: rd %b wr %b addr %h want 0 1 4000", bus.mem_read,
               bus.mem_write, bus.mem_address);
    end
    n_cmp++;
    if (bus.mem_wdata !== LineWb) begin
      n_fail++;
      $display("FAIL d_write_wdata: got %h want %h", bus.mem_wdata, LineWb);
    end
    tick();
    tick();
    bus.mem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b01) begin
      n_fail++;
      $display("FAIL d_write_resp: iresp %b dresp %b want 0 1", bus.i_resp, bus.d_resp);
    end
    tick();
    bus.mem_resp  = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    #1;
    n_cmp++;
    if ({bus.mem_write, bus.d_resp, bus.mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL d_write_idle: wr %b dresp %b wdata %h want 0", bus.mem_write,
               bus.d_resp, bus.mem_wdata);
    end
  endtask

  // Both requesters raised together from IDLE with last_grant = I: D then I, no bubble.
  task automatic both_from_idle(input int round);
    bus.i_read    = 1'b1;
    bus.i_address = 16'h1004;
    bus.d_read    = 1'b1;
    bus.d_address = 16'h200C;
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 16'h2000}) begin
      n_fail++;
      $display("FAIL rr_first_d round %0d: rd %b addr %h want 1 2000", round, bus.mem_read,
               bus.mem_address);
    end
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = Line5a;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp, bus.d_rdata} !== {2'b01, Line5a}) begin
      n_fail++;
      $display("FAIL rr_d_resp round %0d: iresp %b dresp %b rdata %h", round, bus.i_resp,
               bus.d_resp, bus.d_rdata);
    end
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    bus.d_read    = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 16'h1000}) begin
      n_fail++;
      $display("FAIL rr_handoff_i round %0d: rd %b addr %h want 1 1000", round,
               bus.mem_read, bus.mem_address);
    end
    tick();
    bus.mem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_i_resp round %0d: iresp %b dresp %b want 1 0", round, bus.i_resp,
               bus.d_resp);
    end
    tick();
    bus.mem_resp = 1'b0;
    bus.i_read   = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    both_from_idle(0);
    both_from_idle(1);
  endtask

  task automatic test_back_to_back();
    logic        exp_d;
    logic [15:0] exp_addr;
    // Single D transaction leaves last_grant = D.
    bus.d_read    = 1'b1;
    bus.d_address = 16'h2220;
    tick();
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    bus.d_read   = 1'b0;
    #1;
    bus.i_read    = 1'b1;
    bus.i_address = 16'h1110;
    bus.d_read    = 1'b1;
    tick();
    exp_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_resp = 1'b0;
      if (k > 0) begin
        if (exp_d) bus.i_read = 1'b0;
        else bus.d_read = 1'b0;
      end
      #1;
      exp_addr = exp_d ? 16'h2220 : 16'h1110;
      n_cmp++;
      if ({bus.mem_read, bus.mem_write, bus.mem_address} !== {2'b10, exp_addr}) begin
        n_fail++;
        $display("FAIL b2b_grant %0d: rd %b wr %b addr %h want 1 0 %h", k, bus.mem_read,
                 bus.mem_write, bus.mem_address, exp_addr);
      end
      tick();
      bus.i_read   = 1'b1;
      bus.d_read   = 1'b1;
      bus.mem_resp = 1'b1;
      #1;
      n_cmp++;
      if ({bus.i_resp, bus.d_resp} !== {~exp_d, exp_d}) begin
        n_fail++;
        $display("FAIL b2b_resp %0d: iresp %b dresp %b want %b %b", k, bus.i_resp,
                 bus.d_resp, ~exp_d, exp_d);
      end
      tick();
      exp_d = ~exp_d;
    end
    bus.mem_resp  = 1'b0;
    bus.i_read    = 1'b0;
    bus.d_read    = 1'b0;
    bus.d_address = '0;
    reset         = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.d_read    = 1'b1;
    bus.d_address = 16'h3338;
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 16'h3330}) begin
      n_fail++;
      $display("FAIL rst_mid_grant: rd %b addr %h want 1 3330", bus.mem_read,
               bus.mem_address);
    end
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    bus.d_read = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: rd %b wr %b addr %h want 0 0 0000", bus.mem_read,
               bus.mem_write, bus.mem_address);
    end
    tick();
    bus.mem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp, bus.d_resp} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_late_resp: iresp %b dresp %b want 0 0", bus.i_resp,
               bus.d_resp);
    end
    tick();
    bus.mem_resp = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_address !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid_still_idle: addr %h want 0000", bus.mem_address);
    end
  endtask

  task automatic test_idle_resp();
    bus.mem_resp = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_resp_pulse: strobes %b want 0000",
               {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp});
    end
    tick();
    bus.mem_resp = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_address !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle_resp_state: addr %h want 0000", bus.mem_address);
    end
    bus.d_address = '0;
    bus.i_read    = 1'b1;
    bus.i_address = 16'h004F;
    tick();
    n_cmp++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 16'h0040}) begin
      n_fail++;
      $display("FAIL idle_resp_then_grant: rd %b addr %h want 1 0040", bus.mem_read,
               bus.mem_address);
    end
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    bus.i_read   = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_i_read();
    test_d_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_idle_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the instruction cache and data cache for the single shared physical-memory port of the pipelined LC-3b. Each cache issues whole-line (lc3b_data, 128-bit) read or write transactions; the arbiter grants one at a time, forwards it to memory, and routes the response back to the granted cache. It sits between the L1 caches and physical memory, or the L2 when present.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte-address width of lc3b_word addresses.
- LINE_WIDTH, 128, line width; equals the width of lc3b_data.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-cache line address; bits [3:0] are ignored.
- i_rdata  out  LINE_WIDTH  line data returned to the I-cache.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line write (writeback) request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  LINE_WIDTH  writeback line.
- d_rdata  out  LINE_WIDTH  line data returned to the D-cache.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_WIDTH  memory address; bits [3:0] are forced to 0.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_rdata  in  LINE_WIDTH  memory read data; valid when mem_resp is high.
- mem_resp  in  1  memory completion pulse.

## Operation
- States: IDLE, SERVE_I, SERVE_D. A registered last_grant bit holds I or D.
- i_req = i_read; d_req = d_read | d_write. d_read and d_write both high is illegal; behaviour is undefined and the bench flags it with an assertion.
- IDLE: mem_read = mem_write = 0 and mem_address = mem_wdata = 0.
  - Only i_req: go to SERVE_I.
  - Only d_req: go to SERVE_D.
  - Both: grant the requester that is not last_grant (round-robin).
  - Neither: stay in IDLE.
- SERVE_I: mem_read = i_read, mem_write = 0, mem_address = {i_address[15:4], 4'b0}. i_resp = mem_resp, d_resp = 0.
- SERVE_D: mem_read = d_read, mem_write = d_write, mem_address = {d_address[15:4], 4'b0}, mem_wdata = d_wdata. d_resp = mem_resp, i_resp = 0.
- i_rdata and d_rdata are both driven from mem_rdata. Only the resp signal is steered.
- On mem_resp in SERVE_x:
  - last_grant is set to x.
  - If the other requester's req is high in that same cycle, go directly to SERVE_other with no idle bubble.
  - Otherwise go to IDLE.
- mem_resp in IDLE is ignored: no resp pulse and no state change.
- A grant is never preempted. It lasts until mem_resp.
- Requesters must hold address, data and strobes stable from assertion through their resp cycle. They deassert on the cycle after resp.

## Timing
- Reset values: state = IDLE, last_grant = I. All outputs are 0.
- Request seen in IDLE at edge N: mem strobes are high during cycle N+1. mem strobes and resp are combinational from state plus inputs.
- Arbiter overhead is 1 cycle per transaction started from IDLE and 0 cycles for a back-to-back handoff.
- The resp pulse is in the same cycle as mem_resp and is exactly 1 cycle wide.
- Reset mid-transaction: next state is IDLE and strobes drop in the following cycle. A late mem_resp arriving afterwards is ignored.
- Round-robin guarantees each requester waits at most one foreign transaction.

## Test plan
- Reset with both requesters idle: all outputs 0 for 3 cycles. i_read=1 at 0x1234 → mem_read=1 and mem_address=0x1230 the next cycle. Memory responds after 5 cycles with rdata 0xA5…A5 → i_resp for 1 cycle with i_rdata = 0xA5…A5, then IDLE.
- D writeback alone: d_write=1, address 0x4008, wdata 0x0123…EF → mem_write=1, mem_address=0x4000, mem_wdata matches. mem_resp → d_resp=1, i_resp=0.
- Simultaneous i_read and d_read out of reset → D is granted first. On its mem_resp, state moves to SERVE_I with no IDLE cycle. Then both are raised again → D is granted, because last_grant=I.
- Continuous D requests while i_read is held → grants alternate D, I, D. I never waits more than one D transaction.
- Reset asserted during SERVE_D with mem_resp pending → strobes 0 the cycle after reset. mem_resp pulsed later → no d_resp, state stays IDLE.
- mem_resp pulsed while IDLE → i_resp = d_resp = 0 and no state change.
